// File: rtl/axil_mem_responder_pkg.sv
// rtl/axil_mem_responder_pkg.sv - shared AXI4-Lite response codes and grant encoding
package axil_mem_responder_pkg;

    localparam logic [1:0] axil_resp_okay   = 2'b00;
    localparam logic [1:0] axil_resp_slverr = 2'b10;

    typedef enum logic {
        e_grant_read  = 1'b0,
        e_grant_write = 1'b1
    } grant_e;

endpackage

// File: rtl/axil_mem_responder_ram.sv
// rtl/axil_mem_responder_ram.sv - single-port synchronous RAM, 1-cycle read, byte-mask write
module axil_mem_responder_ram #(
    parameter int width = 32,
    parameter int els   = 1024
) (
    input  logic                     aclk,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [$clog2(els)-1:0]   addr_i,
    input  logic [width-1:0]         data_i,
    input  logic [width/8-1:0]       w_mask_i,
    output logic [width-1:0]         data_o
);

    logic [width-1:0] mem [els];
    logic [width-1:0] data_q;
    logic [width-1:0] data_d;

    // Read port: capture the addressed word on a read access, hold it otherwise
    always_comb begin
        data_d = data_q;
        if (v_i && !w_i) begin
            data_d = mem[addr_i];
        end
    end

    // Storage and output register; the array itself is never reset
    always_ff @(posedge aclk) begin
        data_q <= data_d;
        if (v_i && w_i) begin
            for (int b = 0; b < width / 8; b++) begin
                if (w_mask_i[b]) begin
                    mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/axil_mem_responder.sv
// rtl/axil_mem_responder.sv - AXI4-Lite slave terminating on an on-chip word-addressed memory
module axil_mem_responder
    import axil_mem_responder_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int ELS                = 1024
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int WB = $clog2(SW);
    localparam int IW = $clog2(ELS);

    // One-entry holding buffers; the address is stored pre-decoded as index + in-range flag
    logic          aw_full_q, aw_full_d;
    logic [IW-1:0] aw_idx_q, aw_idx_d;
    logic          aw_ok_q, aw_ok_d;
    logic          w_full_q, w_full_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [SW-1:0] w_strb_q, w_strb_d;
    logic          ar_full_q, ar_full_d;
    logic [IW-1:0] ar_idx_q, ar_idx_d;
    logic          ar_ok_q, ar_ok_d;

    // Response channel state
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          read_inflight_q, read_inflight_d;
    grant_e        last_grant_q, last_grant_d;

    logic          aw_hs, w_hs, ar_hs;
    logic          aw_in_range, ar_in_range;
    logic          write_req, read_req;
    logic          grant_write, grant_read;
    logic          ram_v;
    logic [IW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic          unused_bits;

    // Protection bits and sub-word address bits carry no meaning for this memory
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[WB-1:0], s_axi_araddr[WB-1:0]};

    assign s_axi_awready = !aw_full_q;
    assign s_axi_wready  = !w_full_q;
    assign s_axi_arready = !ar_full_q;

    assign aw_hs = s_axi_awvalid && !aw_full_q;
    assign w_hs  = s_axi_wvalid  && !w_full_q;
    assign ar_hs = s_axi_arvalid && !ar_full_q;

    // Anything above the word index makes the access out of range
    assign aw_in_range = (s_axi_awaddr >> (WB + IW)) == '0;
    assign ar_in_range = (s_axi_araddr >> (WB + IW)) == '0;

    // Round-robin arbitration for the single RAM port; a tie goes opposite the last winner
    always_comb begin
        write_req   = aw_full_q && w_full_q && !bvalid_q;
        read_req    = ar_full_q && !rvalid_q && !read_inflight_q;
        grant_write = 1'b0;
        grant_read  = 1'b0;
        if (write_req && read_req) begin
            if (last_grant_q == e_grant_read) begin
                grant_write = 1'b1;
            end else begin
                grant_read = 1'b1;
            end
        end else begin
            grant_write = write_req;
            grant_read  = read_req;
        end
    end

    // Buffer bookkeeping: a grant empties its buffers, a handshake fills them
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_ok_d   = aw_ok_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_full_d = ar_full_q;
        ar_idx_d  = ar_idx_q;
        ar_ok_d   = ar_ok_q;
        if (grant_write) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (grant_read) begin
            ar_full_d = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[WB +: IW];
            aw_ok_d   = aw_in_range;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_idx_d  = s_axi_araddr[WB +: IW];
            ar_ok_d   = ar_in_range;
        end
    end

    // Response channels: raised the cycle after a grant, held until the matching ready
    always_comb begin
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        rvalid_d        = rvalid_q;
        rresp_d         = rresp_q;
        read_inflight_d = grant_read;
        last_grant_d    = last_grant_q;
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (grant_write) begin
            bvalid_d     = 1'b1;
            bresp_d      = aw_ok_q ? axil_resp_okay : axil_resp_slverr;
            last_grant_d = e_grant_write;
        end
        if (grant_read) begin
            rvalid_d     = 1'b1;
            rresp_d      = ar_ok_q ? axil_resp_okay : axil_resp_slverr;
            last_grant_d = e_grant_read;
        end
    end

    // State registers; RAM contents are deliberately left out of reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_full_q       <= 1'b0;
            aw_idx_q        <= '0;
            aw_ok_q         <= 1'b0;
            w_full_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            ar_full_q       <= 1'b0;
            ar_idx_q        <= '0;
            ar_ok_q         <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= axil_resp_okay;
            rvalid_q        <= 1'b0;
            rresp_q         <= axil_resp_okay;
            read_inflight_q <= 1'b0;
            last_grant_q    <= e_grant_read;
        end else begin
            aw_full_q       <= aw_full_d;
            aw_idx_q        <= aw_idx_d;
            aw_ok_q         <= aw_ok_d;
            w_full_q        <= w_full_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            ar_full_q       <= ar_full_d;
            ar_idx_q        <= ar_idx_d;
            ar_ok_q         <= ar_ok_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            rvalid_q        <= rvalid_d;
            rresp_q         <= rresp_d;
            read_inflight_q <= read_inflight_d;
            last_grant_q    <= last_grant_d;
        end
    end

    // Out-of-range accesses never touch the RAM
    assign ram_v    = (grant_write && aw_ok_q) || (grant_read && ar_ok_q);
    assign ram_addr = grant_write ? aw_idx_q : ar_idx_q;

    axil_mem_responder_ram #(
        .width (DW),
        .els   (ELS)
    ) u_ram (
        .aclk     (aclk),
        .v_i      (ram_v),
        .w_i      (grant_write),
        .addr_i   (ram_addr),
        .data_i   (w_data_q),
        .w_mask_i (w_strb_q),
        .data_o   (ram_rdata)
    );

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    // RAM output is only meaningful while an in-range read response is presented
    assign s_axi_rdata  = (rvalid_q && (rresp_q == axil_resp_okay)) ? ram_rdata : '0;

endmodule

// File: tb/tb_axil_mem_responder.sv
// tb/tb_axil_mem_responder.sv - scoreboard bench for axil_mem_responder
module tb_axil_mem_responder;
    import axil_mem_responder_pkg::*;

    logic        aclk;
    logic        areset;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int          n_cmp;
    int          n_bad;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [31:0] model [1024];

    axil_mem_responder #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .ELS                (1024)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // One clock: scoreboard pops on the falling edge, caller resumes just after the rising edge
    task automatic cycle();
        logic [1:0]  eb;
        logic [33:0] er;
        @(negedge aclk);
        if (areset !== 1'b1 && s_axi_bvalid === 1'b1 && s_axi_bready === 1'b1) begin
            n_cmp++;
            if (bq.size() == 0) begin
                n_bad++;
                $display("FAIL b_unexpected: got bresp %b, required no response", s_axi_bresp);
            end else begin
                eb = bq.pop_front();
                if (s_axi_bresp !== eb) begin
                    n_bad++;
                    $display("FAIL b_resp: got %b, required %b", s_axi_bresp, eb);
                end
            end
        end
        if (areset !== 1'b1 && s_axi_rvalid === 1'b1 && s_axi_rready === 1'b1) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL r_unexpected: got rresp %b rdata %h, required no response", s_axi_rresp, s_axi_rdata);
            end else begin
                er = rq.pop_front();
                if ({s_axi_rresp, s_axi_rdata} !== er) begin
                    n_bad++;
                    $display("FAIL r_beat: got resp %b data %h, required resp %b data %h",
                             s_axi_rresp, s_axi_rdata, er[33:32], er[31:0]);
                end
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [9:0] idx;
        idx = addr[11:2];
        if ((addr >> 12) == 32'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
            bq.push_back(axil_resp_okay);
        end else begin
            bq.push_back(axil_resp_slverr);
        end
    endtask

    task automatic push_read(input logic [31:0] addr);
        logic [9:0] idx;
        idx = addr[11:2];
        if ((addr >> 12) == 32'd0) rq.push_back({axil_resp_okay, model[idx]});
        else                       rq.push_back({axil_resp_slverr, 32'h0});
    endtask

    task automatic write_same(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_done, w_done;
        int   n;
        push_write(addr, data, strb);
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
            cycle();
            n++;
            if (aw_done) s_axi_awvalid = 1'b0;
            if (w_done) s_axi_wvalid = 1'b0;
        end
        if (n >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL write_accept_timeout: got no AW/W handshake, required one within 50 cycles");
        end
    endtask

    task automatic read_addr(input logic [31:0] addr, input bit expect_resp);
        int n;
        if (expect_resp) push_read(addr);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; n = 0;
        while (s_axi_arready !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        s_axi_arvalid = 1'b0;
        if (n >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL read_accept_timeout: got no AR handshake, required one within 50 cycles");
        end
    endtask

    task automatic wait_bvalid(output int lat);
        lat = 0;
        while (s_axi_bvalid !== 1'b1 && lat < 50) begin
            cycle();
            lat++;
        end
        if (lat >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL b_timeout: got no bvalid, required one within 50 cycles");
        end
    endtask

    task automatic wait_rvalid(output int lat);
        lat = 0;
        while (s_axi_rvalid !== 1'b1 && lat < 50) begin
            cycle();
            lat++;
        end
        if (lat >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL r_timeout: got no rvalid, required one within 50 cycles");
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) cycle();
        areset = 1'b0;
        n_cmp++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             s_axi_bresp, s_axi_rresp} !== 9'b111_0_0_00_00) begin
            n_bad++;
            $display("FAIL reset_ctrl: got aw/w/ar_ready,bvalid,rvalid,bresp,rresp=%b, required 111000000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp});
        end
        n_cmp++;
        if (s_axi_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h, required 00000000", s_axi_rdata);
        end
    endtask

    task automatic test_basic();
        int lat;
        write_same(32'h10, 32'hDEADBEEF, 4'hF);
        n_cmp++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL basic_t1: got awready,wready,bvalid=%b, required 000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        wait_bvalid(lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL basic_b_latency: got %0d cycles after accept, required 1", lat);
        end
        n_cmp++;
        if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
            n_bad++;
            $display("FAIL basic_t2_ready: got %b, required 11", {s_axi_awready, s_axi_wready});
        end
        cycle();
        read_addr(32'h10, 1'b1);
        wait_rvalid(lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL basic_r_latency: got %0d cycles after accept, required 1", lat);
        end
        n_cmp++;
        if (s_axi_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL basic_rdata: got %h, required deadbeef", s_axi_rdata);
        end
        cycle();
    endtask

    task automatic test_strobe();
        int lat;
        write_same(32'h20, 32'hFFFFFFFF, 4'hF);
        wait_bvalid(lat);
        cycle();
        write_same(32'h20, 32'h11223344, 4'b0101);
        wait_bvalid(lat);
        cycle();
        read_addr(32'h20, 1'b1);
        wait_rvalid(lat);
        n_cmp++;
        if (s_axi_rdata !== 32'hFF22FF44) begin
            n_bad++;
            $display("FAIL strobe_rdata: got %h, required ff22ff44", s_axi_rdata);
        end
        cycle();
    endtask

    task automatic test_split_stall();
        int   lat;
        logic held;
        s_axi_bready = 1'b0;
        push_write(32'h40, 32'hA5A5A5A5, 4'hF);
        s_axi_awaddr = 32'h40; s_axi_awvalid = 1'b1;
        cycle();
        s_axi_awvalid = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b010) begin
            n_bad++;
            $display("FAIL split_waiting_w: got awready,wready,bvalid=%b, required 010",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        s_axi_wdata = 32'hA5A5A5A5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        cycle();
        s_axi_wvalid = 1'b0;
        n_cmp++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL split_issue_cycle: got awready,wready,bvalid=%b, required 000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        cycle();
        n_cmp++;
        if (s_axi_bvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL split_bvalid: got %b, required 1", s_axi_bvalid);
        end
        push_write(32'h44, 32'h5A5A0000, 4'hF);
        s_axi_awaddr = 32'h44; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5A5A0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            s_axi_awvalid = 1'b0;
            s_axi_wvalid = 1'b0;
            if (!(s_axi_bvalid === 1'b1 && s_axi_bresp === axil_resp_okay)) held = 1'b0;
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++;
            $display("FAIL b_held_stable: got bvalid/bresp change under bready=0, required stable 1/00");
        end
        n_cmp++;
        if ({s_axi_awready, s_axi_wready} !== 2'b00) begin
            n_bad++;
            $display("FAIL second_write_held: got awready,wready=%b, required 00", {s_axi_awready, s_axi_wready});
        end
        read_addr(32'h10, 1'b1);
        wait_rvalid(lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL read_during_b_stall: got latency %0d, required 1", lat);
        end
        cycle();
        s_axi_bready = 1'b1;
        cycle();
        wait_bvalid(lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL second_write_latency: got %0d, required 1", lat);
        end
        cycle();
        read_addr(32'h40, 1'b1);
        wait_rvalid(lat);
        cycle();
        read_addr(32'h44, 1'b1);
        wait_rvalid(lat);
        cycle();
    endtask

    task automatic test_out_of_range();
        int lat;
        write_same(32'h0, 32'hCAFEF00D, 4'hF);
        wait_bvalid(lat);
        cycle();
        write_same(32'h1000, 32'h12345678, 4'hF);
        wait_bvalid(lat);
        n_cmp++;
        if (s_axi_bresp !== 2'b10) begin
            n_bad++;
            $display("FAIL oor_bresp: got %b, required 10", s_axi_bresp);
        end
        cycle();
        read_addr(32'h0, 1'b1);
        wait_rvalid(lat);
        cycle();
        read_addr(32'h1000, 1'b1);
        wait_rvalid(lat);
        n_cmp++;
        if ({s_axi_rresp, s_axi_rdata} !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL oor_read: got resp %b data %h, required 10 00000000", s_axi_rresp, s_axi_rdata);
        end
        cycle();
    endtask

    task automatic test_tie();
        int lat;
        areset = 1'b1;
        cycle();
        cycle();
        areset = 1'b0;
        push_write(32'h30, 32'h0BADC0DE, 4'hF);
        push_read(32'h10);
        s_axi_awaddr = 32'h30; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0BADC0DE; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h10; s_axi_arvalid = 1'b1;
        cycle();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        cycle();
        n_cmp++;
        if ({s_axi_bvalid, s_axi_rvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL tie1_write_first: got bvalid,rvalid=%b, required 10", {s_axi_bvalid, s_axi_rvalid});
        end
        cycle();
        n_cmp++;
        if ({s_axi_bvalid, s_axi_rvalid} !== 2'b01) begin
            n_bad++;
            $display("FAIL tie1_read_next: got bvalid,rvalid=%b, required 01", {s_axi_bvalid, s_axi_rvalid});
        end
        cycle();
        write_same(32'h34, 32'h600DF00D, 4'hF);
        wait_bvalid(lat);
        cycle();
        push_write(32'h38, 32'h13579BDF, 4'hF);
        push_read(32'h30);
        s_axi_awaddr = 32'h38; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h13579BDF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h30; s_axi_arvalid = 1'b1;
        cycle();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        cycle();
        n_cmp++;
        if ({s_axi_bvalid, s_axi_rvalid} !== 2'b01) begin
            n_bad++;
            $display("FAIL tie2_read_first: got bvalid,rvalid=%b, required 01", {s_axi_bvalid, s_axi_rvalid});
        end
        cycle();
        n_cmp++;
        if ({s_axi_bvalid, s_axi_rvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL tie2_write_next: got bvalid,rvalid=%b, required 10", {s_axi_bvalid, s_axi_rvalid});
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int acc, seen, t, last_t;
        logic hs;
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h30; addrs[3] = 32'h34;
        acc = 0; seen = 0; t = 0; last_t = 0;
        s_axi_araddr = addrs[0]; s_axi_arvalid = 1'b1;
        while (seen < 4 && t < 60) begin
            hs = 1'b0;
            if (s_axi_arvalid && s_axi_arready) begin
                push_read(addrs[acc]);
                acc++;
                hs = 1'b1;
            end
            cycle();
            t++;
            if (hs) begin
                if (acc < 4) s_axi_araddr = addrs[acc];
                else         s_axi_arvalid = 1'b0;
            end
            if (s_axi_rvalid === 1'b1) begin
                seen++;
                last_t = t;
            end
        end
        cycle();
        n_cmp++;
        if (last_t !== 8) begin
            n_bad++;
            $display("FAIL b2b_read_throughput: got 4th rvalid at cycle %0d, required 8", last_t);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        s_axi_rready = 1'b0;
        read_addr(32'h20, 1'b0);
        s_axi_awaddr = 32'h50; s_axi_awvalid = 1'b1;
        cycle();
        s_axi_awvalid = 1'b0;
        wait_rvalid(lat);
        n_cmp++;
        if ({s_axi_rvalid, s_axi_awready} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_pre_reset: got rvalid,awready=%b, required 10", {s_axi_rvalid, s_axi_awready});
        end
        areset = 1'b1;
        cycle();
        n_cmp++;
        if ({s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 5'b00111) begin
            n_bad++;
            $display("FAIL mid_reset_clears: got rvalid,bvalid,aw/w/ar_ready=%b, required 00111",
                     {s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready});
        end
        areset = 1'b0;
        s_axi_rready = 1'b1;
        cycle();
        read_addr(32'h20, 1'b1);
        wait_rvalid(lat);
        n_cmp++;
        if (s_axi_rdata !== 32'hFF22FF44) begin
            n_bad++;
            $display("FAIL mid_retained: got %h, required ff22ff44", s_axi_rdata);
        end
        cycle();
        read_addr(32'h40, 1'b1);
        wait_rvalid(lat);
        cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        test_reset();
        test_basic();
        test_strobe();
        test_split_stall();
        test_out_of_range();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        repeat (3) cycle();
        n_cmp++;
        if (bq.size() != 0 || rq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drained: got %0d B and %0d R pending, required 0 and 0", bq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
